contador_de_programa: RTL

//  Fetch-stage program counter for the single-cycle iZero core; drives pc into the instruction ROM and consumes
//  the returned instruction word to pick the next pc (sequential, j, jal, jr, jf).

---
 rtl/contador_de_programa_pkg.sv | 19 +
 rtl/contador_de_programa_if.sv | 29 ++
 rtl/contador_de_programa_calcula_proximo_pc.sv | 52 +++++
 rtl/contador_de_programa.sv | 96 +++++++++
 4 files changed

// File: rtl/contador_de_programa_pkg.sv
// Shared opcode, funct and run-state definitions for the iZero fetch stage.
package pacote_cpu;

  localparam logic [5:0] OP_J     = 6'b010110;
  localparam logic [5:0] OP_JAL   = 6'b010111;
  localparam logic [5:0] OP_JF    = 6'b010101;
  localparam logic [5:0] OP_HALT  = 6'b011000;
  localparam logic [5:0] OP_IN    = 6'b010011;
  localparam logic [5:0] OP_RTYPE = 6'b000000;

  localparam logic [5:0] FUNCT_JR = 6'b010010;

  typedef enum logic [1:0] {
    ESTADO_EXEC    = 2'b00,
    ESTADO_WAIT_IN = 2'b01,
    ESTADO_HALTED  = 2'b10
  } estado_t;

endpackage

// File: rtl/contador_de_programa_if.sv
// Bus between the program counter and the rest of the core (ROM, register file, user input, debug).
interface contador_de_programa_if #(
  parameter int PC_W = 26
);

  logic [31:0]     instrucao;
  logic [31:0]     dado_rs;
  logic            in_valido;
  logic [PC_W-1:0] pc;
  logic            ra_we;
  logic [31:0]     ra_dado;
  logic            in_pedido;
  logic            parado;
  logic            erro;
  logic [31:0]     contador;

  // Core side: supplies instruction/operands, observes pc and status.
  modport master (
    output instrucao, dado_rs, in_valido,
    input  pc, ra_we, ra_dado, in_pedido, parado, erro, contador
  );

  // Program-counter side.
  modport slave (
    input  instrucao, dado_rs, in_valido,
    output pc, ra_we, ra_dado, in_pedido, parado, erro, contador
  );

endinterface

// File: rtl/contador_de_programa_calcula_proximo_pc.sv
// Combinational decode of the current instruction into the next pc and control flags.
module calcula_proximo_pc
  import pacote_cpu::*;
#(
  parameter int MEM_SIZE = 150,
  parameter int PC_W     = 26
) (
  input  logic [31:0]     instrucao,
  input  logic [PC_W-1:0] pc,
  input  logic [31:0]     dado_rs,
  output logic [PC_W-1:0] proximo_pc,
  output logic            fora_de_faixa,
  output logic            eh_jal,
  output logic            eh_in,
  output logic            eh_halt
);

  localparam logic [PC_W:0] LIMITE = (PC_W + 1)'(MEM_SIZE);

  logic [5:0]      opcode;
  logic [5:0]      funct;
  logic [PC_W-1:0] pc_mais_um;

  assign opcode     = instrucao[31:26];
  assign funct      = instrucao[5:0];
  assign pc_mais_um = pc + PC_W'(1);

  // Target selection by opcode; everything not a jump falls through to pc+1.
  always_comb begin
    proximo_pc = pc_mais_um;
    eh_jal     = 1'b0;
    eh_in      = 1'b0;
    eh_halt    = 1'b0;
    unique case (opcode)
      OP_J:    proximo_pc = PC_W'(instrucao[25:0]);
      OP_JAL: begin
        proximo_pc = PC_W'(instrucao[25:0]);
        eh_jal     = 1'b1;
      end
      OP_JF:   proximo_pc = (dado_rs == '0) ? PC_W'(instrucao[15:0]) : pc_mais_um;
      OP_HALT: eh_halt = 1'b1;
      OP_IN:   eh_in   = 1'b1;
      OP_RTYPE: begin
        if (funct == FUNCT_JR) proximo_pc = PC_W'(dado_rs[25:0]);
      end
      default: proximo_pc = pc_mais_um;
    endcase
  end

  assign fora_de_faixa = ({1'b0, proximo_pc} >= LIMITE);

endmodule

// File: rtl/contador_de_programa.sv
// Fetch-stage program counter: pc register, run-state FSM and executed-instruction counter.
module contador_de_programa
  import pacote_cpu::*;
#(
  parameter int MEM_SIZE = 150,
  parameter int PC_W     = 26
) (
  input logic                    clock,
  input logic                    reset,
  contador_de_programa_if.slave  bus
);

  estado_t         estado;
  logic [PC_W-1:0] pc;
  logic [PC_W-1:0] pc_mais_um;
  logic [PC_W-1:0] proximo_pc;
  logic            fora_de_faixa;
  logic            eh_jal;
  logic            eh_in;
  logic            eh_halt;

  calcula_proximo_pc #(
    .MEM_SIZE (MEM_SIZE),
    .PC_W     (PC_W)
  ) u_calcula (
    .instrucao     (bus.instrucao),
    .pc            (pc),
    .dado_rs       (bus.dado_rs),
    .proximo_pc    (proximo_pc),
    .fora_de_faixa (fora_de_faixa),
    .eh_jal        (eh_jal),
    .eh_in         (eh_in),
    .eh_halt       (eh_halt)
  );

  assign pc_mais_um = pc + PC_W'(1);

  // Run-state FSM with pc, counter, parado and erro registers.
  always_ff @(posedge clock) begin
    if (!reset) begin
      estado       <= ESTADO_EXEC;
      pc           <= '0;
      bus.parado   <= 1'b0;
      bus.erro     <= 1'b0;
      bus.contador <= '0;
    end else begin
      unique case (estado)
        ESTADO_EXEC: begin
          if (eh_halt) begin
            estado       <= ESTADO_HALTED;
            bus.parado   <= 1'b1;
            bus.contador <= bus.contador + 32'd1;
          end else if (eh_in) begin
            if (bus.in_valido) begin
              pc           <= pc_mais_um;
              bus.contador <= bus.contador + 32'd1;
            end else begin
              estado <= ESTADO_WAIT_IN;
            end
          end else if (fora_de_faixa) begin
            estado     <= ESTADO_HALTED;
            bus.parado <= 1'b1;
            bus.erro   <= 1'b1;
          end else begin
            pc           <= proximo_pc;
            bus.contador <= bus.contador + 32'd1;
          end
        end
        ESTADO_WAIT_IN: begin
          if (bus.in_valido) begin
            estado       <= ESTADO_EXEC;
            pc           <= pc_mais_um;
            bus.contador <= bus.contador + 32'd1;
          end
        end
        ESTADO_HALTED: begin
          estado <= ESTADO_HALTED;
        end
        default: begin
          estado     <= ESTADO_HALTED;
          bus.parado <= 1'b1;
        end
      endcase
    end
  end

  // Combinational handshake outputs derived from current state and instruction.
  always_comb begin
    bus.pc        = pc;
    bus.ra_dado   = 32'(pc_mais_um);
    bus.ra_we     = (estado == ESTADO_EXEC) && eh_jal && !fora_de_faixa;
    bus.in_pedido = (estado == ESTADO_WAIT_IN) ||
                    ((estado == ESTADO_EXEC) && eh_in && !bus.in_valido);
  end

endmodule
